// File: rtl/fp_mult_seq_if.sv
// Operand/result handshake bundle for the sequential IEEE-754 multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface fp_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [2:0]       exc;

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, res, exc
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, res, exc
  );
endinterface

// File: rtl/fp_mult_seq.sv
// Multi-cycle IEEE-754 multiplier: one-cycle special-case resolution, otherwise
// shift-add mantissa multiply, normalize and round-to-nearest-even (denormals flushed).
module fp_mult_seq #(
  parameter bit IS_DOUBLE  = 1'b0,
  parameter int WIDTH      = IS_DOUBLE ? 64 : 32,
  parameter int EXPONENT_W = IS_DOUBLE ? 11 : 8,
  parameter int MANTISSA_W = IS_DOUBLE ? 52 : 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mult_seq_if.slave bus
);
  localparam int SIG_W  = MANTISSA_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EXP_RW = EXPONENT_W + 2;
  localparam int CNT_W  = $clog2(SIG_W + 1);

  localparam logic signed [EXP_RW-1:0] BIAS     = EXP_RW'((1 << (EXPONENT_W - 1)) - 1);
  localparam logic signed [EXP_RW-1:0] EXP_MAX  = EXP_RW'((1 << EXPONENT_W) - 1);
  localparam logic signed [EXP_RW-1:0] EXP_ONE  = EXP_RW'(1);
  localparam logic signed [EXP_RW-1:0] EXP_ZERO = '0;

  typedef enum logic [2:0] {IDLE, CLASS, MUL, NORM, RND, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [WIDTH-1:0]         op1_reg, op1_next, op2_reg, op2_next;
  logic [SIG_W-1:0]         mcand_reg, mcand_next, mplier_reg, mplier_next;
  logic [PROD_W-1:0]        acc_reg, acc_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic signed [EXP_RW-1:0] exp_reg, exp_next;
  logic                     sign_reg, sign_next;
  logic [MANTISSA_W-1:0]    mant_reg, mant_next;
  logic                     guard_reg, guard_next, sticky_reg, sticky_next;
  logic [WIDTH-1:0]         res_reg, res_next;
  logic [2:0]               exc_reg, exc_next;
  logic                     out_valid_reg, out_valid_next;

  logic                     s1, s2;
  logic [EXPONENT_W-1:0]    e1, e2;
  logic [MANTISSA_W-1:0]    m1, m2;
  logic                     nan1, nan2, inf1, inf2, zero1, zero2;
  logic [SIG_W:0]           partial;
  logic                     round_up, carry;
  logic [MANTISSA_W-1:0]    mant_rnd;
  logic signed [EXP_RW-1:0] exp_rnd;

  assign {s1, e1, m1} = op1_reg;
  assign {s2, e2, m2} = op2_reg;
  assign nan1  = (&e1) && (|m1);
  assign nan2  = (&e2) && (|m2);
  assign inf1  = (&e1) && !(|m1);
  assign inf2  = (&e2) && !(|m2);
  assign zero1 = (e1 == '0);
  assign zero2 = (e2 == '0);

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.res       = res_reg;
  assign bus.exc       = exc_reg;

  // Shift-add step: add the multiplicand into the upper half, then shift the whole accumulator right.
  assign partial = {1'b0, acc_reg[PROD_W-1:SIG_W]} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);

  assign round_up          = guard_reg & (sticky_reg | mant_reg[0]);
  assign {carry, mant_rnd} = {1'b0, mant_reg} + {{MANTISSA_W{1'b0}}, round_up};
  assign exp_rnd           = carry ? exp_reg + EXP_ONE : exp_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op1_reg       <= '0;
      op2_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      exp_reg       <= '0;
      sign_reg      <= 1'b0;
      mant_reg      <= '0;
      guard_reg     <= 1'b0;
      sticky_reg    <= 1'b0;
      res_reg       <= '0;
      exc_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op1_reg       <= op1_next;
      op2_reg       <= op2_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      exp_reg       <= exp_next;
      sign_reg      <= sign_next;
      mant_reg      <= mant_next;
      guard_reg     <= guard_next;
      sticky_reg    <= sticky_next;
      res_reg       <= res_next;
      exc_reg       <= exc_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op1_next       = op1_reg;
    op2_next       = op2_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    exp_next       = exp_reg;
    sign_next      = sign_reg;
    mant_next      = mant_reg;
    guard_next     = guard_reg;
    sticky_next    = sticky_reg;
    res_next       = res_reg;
    exc_next       = exc_reg;
    out_valid_next = out_valid_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          op1_next   = bus.op1;
          op2_next   = bus.op2;
          state_next = CLASS;
        end
      end

      CLASS: begin
        sign_next = s1 ^ s2;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
          res_next   = {1'b0, {EXPONENT_W{1'b1}}, 1'b1, {(MANTISSA_W-1){1'b0}}};
          exc_next   = 3'b100;
          state_next = DONE;
        end else if (inf1 || inf2) begin
          res_next   = {s1 ^ s2, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
          exc_next   = 3'b000;
          state_next = DONE;
        end else if (zero1 || zero2) begin
          res_next   = {s1 ^ s2, {(WIDTH-1){1'b0}}};
          exc_next   = 3'b000;
          state_next = DONE;
        end else begin
          mcand_next  = {1'b1, m1};
          mplier_next = {1'b1, m2};
          acc_next    = '0;
          cnt_next    = '0;
          exp_next    = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS;
          state_next  = MUL;
        end
      end

      MUL: begin
        acc_next    = {partial, acc_reg[SIG_W-1:1]};
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(SIG_W - 1)) begin
          state_next = NORM;
        end
      end

      NORM: begin
        // Product of two [1,2) significands lies in [1,4): leading one is one of the top two bits.
        if (acc_reg[PROD_W-1]) begin
          mant_next   = acc_reg[PROD_W-2:SIG_W];
          guard_next  = acc_reg[SIG_W-1];
          sticky_next = |acc_reg[SIG_W-2:0];
          exp_next    = exp_reg + EXP_ONE;
        end else begin
          mant_next   = acc_reg[PROD_W-3:SIG_W-1];
          guard_next  = acc_reg[SIG_W-2];
          sticky_next = |acc_reg[SIG_W-3:0];
        end
        state_next = RND;
      end

      RND: begin
        if (exp_rnd >= EXP_MAX) begin
          res_next = {sign_reg, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
          exc_next = 3'b010;
        end else if (exp_rnd <= EXP_ZERO) begin
          res_next = {sign_reg, {(WIDTH-1){1'b0}}};
          exc_next = 3'b001;
        end else begin
          res_next = {sign_reg, exp_rnd[EXPONENT_W-1:0], mant_rnd};
          exc_next = 3'b000;
        end
        state_next = DONE;
      end

      DONE: begin
        // out_valid rises one cycle after entering DONE and drops on the accepting edge.
        if (out_valid_reg && bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end else begin
          out_valid_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboarded bench for fp_mult_seq (binary32): directed test-plan vectors,
// backpressure, mid-operation reset and randomized operands vs. an arithmetic model.
module tb_fp_mult_seq;
  localparam int WIDTH = 32;
  localparam int LAT_SPECIAL = 2;
  localparam int LAT_NORMAL  = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mult_seq_if #(.WIDTH(WIDTH)) bus ();

  fp_mult_seq #(.IS_DOUBLE(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  exc;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          hold_ready = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_res;
  logic [2:0]  prev_exc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder against one half.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [2:0] x, output bit special);
    int ea, eb, e, sh;
    longint unsigned ma, mb, prod, q, rem, half;
    bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    nan_a  = (ea == 255) && (ma != 0);
    nan_b  = (eb == 255) && (mb != 0);
    inf_a  = (ea == 255) && (ma == 0);
    inf_b  = (eb == 255) && (mb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    special = 1'b1;
    x = 3'b000;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      r = 32'h7FC00000;
      x = 3'b100;
    end else if (inf_a || inf_b) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zero_a || zero_b) begin
      r = {s, 31'h0};
    end else begin
      special = 1'b0;
      prod = (ma + (64'd1 << 23)) * (mb + (64'd1 << 23));
      e    = ea + eb - 127;
      sh   = (prod >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e++;
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        x = 3'b010;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        x = 3'b001;
      end else begin
        r = {s, e[7:0], q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int c;
    v = $urandom;
    c = $urandom_range(0, 11);
    case (c)
      0: v[30:23] = 8'hFF;
      1: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      2: v[30:23] = 8'h00;
      3: v[30:23] = 8'($urandom_range(230, 254));
      4: v[30:23] = 8'($urandom_range(1, 30));
      5: begin v[30:23] = 8'($urandom_range(100, 150)); v[22:0] = 23'h7FFFFF; end
      default: v[30:23] = 8'($urandom_range(64, 190));
    endcase
    return v;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [2:0] x, input bit special);
    exp_t e;
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1 = a;
    bus.op2 = b;
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready never rose for %h * %h", a, b);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    e.a = a;
    e.b = b;
    e.res = r;
    e.exc = x;
    e.due = cyc + (special ? LAT_SPECIAL : LAT_NORMAL);
    exp_q.push_back(e);
  endtask

  task automatic send_rand();
    logic [31:0] a, b, r;
    logic [2:0] x;
    bit sp;
    a = rand_op();
    b = rand_op();
    model(a, b, r, x, sp);
    send(a, b, r, x, sp);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Consumer: random backpressure unless a directed test holds it off.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on the rising edge of out_valid, stability while stalled, compare on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_out_valid", 64'(bus.out_valid), 64'd1);
        check("hold_res", 64'(bus.res), 64'(prev_res));
        check("hold_exc", 64'(bus.exc), 64'(prev_exc));
      end
      if (bus.out_valid) begin
        check("busy_in_ready", 64'(bus.in_ready), 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: res %h exc %b with empty scoreboard", bus.res, bus.exc);
        end else begin
          if (!prev_hold) check("latency", 64'(cyc), 64'(exp_q[0].due));
          if (bus.out_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("[TB] %h * %h -> res %h exc %b (want %h %b)", e.a, e.b, bus.res, bus.exc, e.res, e.exc);
            check("res", 64'(bus.res), 64'(e.res));
            check("exc", 64'(bus.exc), 64'(e.exc));
          end
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_res  = bus.res;
      prev_exc  = bus.exc;
    end
  end

  initial begin
    if (!$isunknown(cyc)) begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
    end
  end

  logic [31:0] dir_a   [10] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h7FC00000, 32'h7F800000,
                                32'h7F800000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'hBF800000};
  logic [31:0] dir_b   [10] = '{32'h40200000, 32'h3FC00000, 32'h3F800001, 32'h3F800000, 32'h00000000,
                                32'hC0000000, 32'h40000000, 32'h7F000000, 32'h80800000, 32'h3F800000};
  logic [31:0] dir_res [10] = '{32'h40F00000, 32'h40100000, 32'h3F800002, 32'h7FC00000, 32'h7FC00000,
                                32'hFF800000, 32'h00000000, 32'h7F800000, 32'h80000000, 32'hBF800000};
  logic [2:0]  dir_exc [10] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100,
                                3'b000, 3'b000, 3'b010, 3'b001, 3'b000};
  bit          dir_sp  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int waited;
    bus.in_valid = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_res", 64'(bus.res), 64'd0);
    check("reset_exc", 64'(bus.exc), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(dir_a[i], dir_b[i], dir_res[i], dir_exc[i], dir_sp[i]);
    end
    drain();

    // Stalled consumer: result must hold and new operands must be refused.
    hold_ready = 1'b1;
    send(32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, 1'b0);
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("bp_reached_done", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op1 = $urandom;
      bus.op2 = $urandom;
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_res", 64'(bus.res), 64'h40F00000);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    hold_ready = 1'b0;
    drain();

    // Asynchronous reset in the middle of the mantissa multiply.
    send(32'h40400000, 32'h40200000, 32'h40F00000, 3'b000, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_res", 64'(bus.res), 64'd0);
    check("midrst_exc", 64'(bus.exc), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 1'b0);
    drain();

    for (int i = 0; i < 250; i++) begin
      send_rand();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
